prbs_gen_multi: RTL and testbench
=================================

// Module: prbs_gen_multi
// PURPOSE
//  Parametrised parallel PRBS pattern generator for SERDES link bring-up on KC705.
//  Produces DATA_W bits per clock from a run-time selectable ITU polynomial (PRBS7/15/23/31).
//  Output uses a valid/ready handshake, supports reseeding and single-bit error injection,
//  and counts accepted words. Feeds the TX data path / loopback checker.
// PARAMETERS
//  DATA_W   32            output word width, bits per cycle (1..64)
//  SEED     31'h7FFFFFFF  LFSR seed, masked to the active polynomial length N; zero after mask -> all ones
//  CNT_W    32            width of accepted-word counter
// PORTS
//  clk       in   1       single clock, all logic rising-edge
//  rst       in   1       synchronous, active-high reset
//  en        in   1       generate enable
//  mode      in   2       00 PRBS7, 01 PRBS15, 10 PRBS23, 11 PRBS31; sampled only at rst or load
//  load      in   1       1-cycle pulse: latch mode, reseed LFSR, drop out_valid
//  inj_err   in   1       1-cycle pulse: invert bit 0 of next generated word
//  out_data  out  DATA_W  PRBS word; bit 0 = earliest bit in sequence
//  out_valid out  1       out_data holds a valid word
//  out_ready in   1       downstream accepts word when out_valid & out_ready
//  word_cnt  out  CNT_W   count of accepted words, saturates at all ones
// BEHAVIOUR
//  LFSR: Fibonacci, state s[30:0], active length N with tap T:
//   PRBS7 N=7 T=6; PRBS15 N=15 T=14; PRBS23 N=23 T=18; PRBS31 N=31 T=28.
//   One bit step: o = s[N-1]; s[N-1:0] <= {s[N-2:0], s[N-1]^s[T-1]}; s[30:N] held 0.
//   Sequence satisfies o[k+N] = o[k] ^ o[k+N-T]. A word = DATA_W consecutive steps in one cycle.
//  Reset (rst=1): out_data=0, out_valid=0, word_cnt=0, err_pend=0, mode_r<=mode,
//   s <= SEED masked to N (all ones if zero). rst has priority over all other inputs.
//  Advance condition adv = en & (~out_valid | out_ready) & ~load & ~rst.
//  On adv: out_data <= next word (bit0 ^ err_pend), out_valid<=1, LFSR steps DATA_W bits,
//   err_pend<=0. Latency: en high in cycle c (after rst low) -> out_valid=1 in cycle c+1.
//  Stall: out_valid & ~out_ready -> out_data, out_valid, LFSR frozen (no bit lost).
//  en=0 & out_ready & out_valid -> out_valid<=0 next cycle; LFSR frozen; no word skipped.
//  load: mode_r<=mode, s<=SEED masked to new N, out_valid<=0, err_pend<=0; word held
//   at load is discarded even if out_ready=1 that cycle (not counted). Next adv restarts sequence.
//  inj_err: err_pend<=1 (sticky until consumed by next adv). inj_err same cycle as adv:
//   applies to that word. inj_err with load: ignored.
//  word_cnt: +1 each cycle out_valid & out_ready & ~load; saturates, never wraps.
//  State never reaches all zeros in operation; if detected (e.g. SEED misuse) force all ones.
//  No combinational path from inputs to outputs.
// TESTING
//  T1 rst, mode=00, SEED default, en=1, out_ready=1 -> first word bits[13:0]=14'h207F
//     (1111111 then 0000001); word k == word k+127 for all k.
//  T2 Each mode, DATA_W=32, ready=1 for 2^N+ bits -> bit-serial reference model matches,
//     period 2^N-1 bits, no all-zero N-bit run.
//  T3 out_ready toggled random 50% -> concatenated accepted words identical to T1/T2 stream;
//     word_cnt equals number of valid&ready cycles.
//  T4 inj_err pulse while stalled -> next accepted word differs from model only in bit0;
//     following word matches model.
//  T5 Mid-stream load with mode 00->11 -> out_valid=0 next cycle, then PRBS31 from seed
//     7FFFFFFF; discarded word not counted. rst mid-stream -> all outputs 0, restart from seed.
//  T6 word_cnt with CNT_W=4, 20 accepted words -> saturates at 4'hF.

Source files
------------

// File: rtl/prbs_gen_multi_if.sv
// Output stream bundle of the PRBS generator: word, valid/ready handshake and accepted-word count.
interface prbs_gen_multi_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  word_cnt;

    modport master (output out_data, output out_valid, output word_cnt, input out_ready);
    modport slave  (input out_data, input out_valid, input word_cnt, output out_ready);
endinterface

// File: rtl/prbs_gen_multi.sv
// Parallel Fibonacci PRBS7/15/23/31 generator, DATA_W bits per clock, with handshake,
// reseed (load), single-bit error injection and a saturating accepted-word counter.
module prbs_gen_multi #(
    parameter int          DATA_W = 32,
    parameter logic [30:0] SEED   = 31'h7FFFFFFF,
    parameter int          CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [1:0]            mode_i,
    input  logic                  load_i,
    input  logic                  inj_err_i,
    prbs_gen_multi_if.master      bus
);

    function automatic logic [30:0] len_mask(input logic [1:0] m);
        case (m)
            2'b00:   return 31'h0000007F;
            2'b01:   return 31'h00007FFF;
            2'b10:   return 31'h007FFFFF;
            default: return 31'h7FFFFFFF;
        endcase
    endfunction

    function automatic logic [4:0] top_idx(input logic [1:0] m);
        case (m)
            2'b00:   return 5'd6;
            2'b01:   return 5'd14;
            2'b10:   return 5'd22;
            default: return 5'd30;
        endcase
    endfunction

    function automatic logic [4:0] tap_idx(input logic [1:0] m);
        case (m)
            2'b00:   return 5'd5;
            2'b01:   return 5'd13;
            2'b10:   return 5'd17;
            default: return 5'd27;
        endcase
    endfunction

    // A seed that masks to zero would lock the LFSR, so substitute all ones.
    function automatic logic [30:0] seed_for(input logic [1:0] m);
        logic [30:0] s;
        s = SEED & len_mask(m);
        return (s == '0) ? len_mask(m) : s;
    endfunction

    logic [1:0]        mode_q,  mode_d;
    logic [30:0]       lfsr_q,  lfsr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic              err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [30:0]       lfsr_hold;
    logic [30:0]       lfsr_step;
    logic [DATA_W-1:0] word;
    logic              adv;
    logic              accept;

    // Unroll DATA_W single-bit steps; bit 0 of the word is the earliest output bit.
    always_comb begin
        logic [30:0] s;
        logic [30:0] mask;
        logic [4:0]  top;
        logic [4:0]  tap;
        mask      = len_mask(mode_q);
        top       = top_idx(mode_q);
        tap       = tap_idx(mode_q);
        s         = (lfsr_q == '0) ? mask : lfsr_q;
        lfsr_hold = s;
        word      = '0;
        for (int i = 0; i < DATA_W; i++) begin
            word[i] = s[top];
            s       = {s[29:0], s[top] ^ s[tap]} & mask;
        end
        lfsr_step = s;
    end

    assign adv    = en_i & (~valid_q | bus.out_ready) & ~load_i;
    assign accept = valid_q & bus.out_ready & ~load_i;

    always_comb begin
        mode_d  = mode_q;
        lfsr_d  = lfsr_hold;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            mode_d  = mode_i;
            lfsr_d  = seed_for(mode_i);
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            if (adv) begin
                data_d    = word;
                data_d[0] = word[0] ^ (err_q | inj_err_i);
                valid_d   = 1'b1;
                lfsr_d    = lfsr_step;
                err_d     = 1'b0;
            end else begin
                if (accept)    valid_d = 1'b0;
                if (inj_err_i) err_d   = 1'b1;
            end
            if (accept && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= mode_i;
            lfsr_q  <= seed_for(mode_i);
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.word_cnt  = cnt_q;

endmodule

// File: tb/tb_prbs_gen_multi.sv
// Randomized bench for prbs_gen_multi against a bit-stream recurrence model of the PRBS sequence.
module tb_prbs_gen_multi;
    localparam int          DW    = 32;
    localparam logic [30:0] SEEDV = 31'h7FFFFFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_i;
    logic       load_i;
    logic       inj_err_i;
    logic [1:0] mode_i;

    always #5 clk = ~clk;

    prbs_gen_multi_if #(.DATA_W(DW), .CNT_W(32)) bus  ();
    prbs_gen_multi_if #(.DATA_W(DW), .CNT_W(4))  bus4 ();

    assign bus4.out_ready = bus.out_ready;

    prbs_gen_multi #(.DATA_W(DW), .SEED(SEEDV), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i),
        .load_i(load_i), .inj_err_i(inj_err_i), .bus(bus.master)
    );

    prbs_gen_multi #(.DATA_W(DW), .SEED(SEEDV), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i),
        .load_i(load_i), .inj_err_i(inj_err_i), .bus(bus4.master)
    );

    int tests = 0;
    int fails = 0;

    // Reference: the PRBS stream as a bit list built from o[j] = o[j-N] ^ o[j-T].
    bit          hist[$];
    int          n_m;
    int          t_m;
    int          ptr;
    logic        ev;
    logic        pend;
    logic [DW-1:0] exp_data;
    longint      exp_cnt;
    int          exp_cnt4;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_restart(input logic [1:0] md);
        logic [63:0] msk;
        logic [63:0] sd;
        case (md)
            2'd0:    begin n_m = 7;  t_m = 6;  end
            2'd1:    begin n_m = 15; t_m = 14; end
            2'd2:    begin n_m = 23; t_m = 18; end
            default: begin n_m = 31; t_m = 28; end
        endcase
        msk = (64'd1 << n_m) - 64'd1;
        sd  = {33'd0, SEEDV} & msk;
        if (sd == 64'd0) sd = msk;
        hist.delete();
        for (int k = 0; k < n_m; k++) hist.push_back(sd[n_m - 1 - k]);
        ptr = 0;
    endtask

    function automatic bit sbit(input int k);
        int j;
        while (hist.size() <= k) begin
            j = hist.size();
            hist.push_back(hist[j - n_m] ^ hist[j - t_m]);
        end
        return hist[k];
    endfunction

    task automatic next_word(output logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) w[i] = sbit(ptr + i);
        ptr += DW;
    endtask

    task automatic do_reset(input logic [1:0] md);
        rst           = 1'b1;
        en_i          = 1'($urandom);
        load_i        = 1'($urandom);
        inj_err_i     = 1'($urandom);
        bus.out_ready = 1'($urandom);
        mode_i        = md;
        @(posedge clk); #1;
        rst = 1'b0;
        model_restart(md);
        ev       = 1'b0;
        pend     = 1'b0;
        exp_cnt  = 0;
        exp_cnt4 = 0;
        check("rst_data",  64'(bus.out_data),  64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_cnt",   64'(bus.word_cnt),  64'd0);
        check("rst_cnt4",  64'(bus4.word_cnt), 64'd0);
    endtask

    task automatic step(input logic en, input logic rdy, input logic ld, input logic inj,
                        input logic [1:0] md);
        logic [DW-1:0] w;
        en_i          = en;
        bus.out_ready = rdy;
        load_i        = ld;
        inj_err_i     = inj;
        mode_i        = md;
        if (ev) check("data", 64'(bus.out_data), 64'(exp_data));
        if (ev && rdy && !ld) begin
            exp_cnt++;
            if (exp_cnt4 < 15) exp_cnt4++;
        end
        if (ld) begin
            model_restart(md);
            ev   = 1'b0;
            pend = 1'b0;
        end else if (en && (!ev || rdy)) begin
            next_word(w);
            w[0]     = w[0] ^ (pend | inj);
            exp_data = w;
            ev       = 1'b1;
            pend     = 1'b0;
        end else begin
            if (ev && rdy) ev = 1'b0;
            if (inj) pend = 1'b1;
        end
        @(posedge clk); #1;
        check("valid", 64'(bus.out_valid), 64'(ev));
        check("cnt",   64'(bus.word_cnt),  64'(exp_cnt));
        check("cnt4",  64'(bus4.word_cnt), 64'(exp_cnt4));
    endtask

    task automatic rstep(input int en_pct, input int rdy_pct, input int ld_pct, input int inj_pct);
        step(($urandom_range(99) < en_pct), ($urandom_range(99) < rdy_pct),
             ($urandom_range(99) < ld_pct), ($urandom_range(99) < inj_pct),
             2'($urandom));
    endtask

    initial begin
        rst = 1'b1; en_i = 1'b0; load_i = 1'b0; inj_err_i = 1'b0; mode_i = 2'd0;
        bus.out_ready = 1'b0;

        // PRBS7 first word and sustained full-rate stream
        do_reset(2'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'($urandom));
        check("t1_first", 64'(bus.out_data[13:0]), 64'h207F);
        for (int i = 0; i < 300; i++) rstep(100, 100, 0, 0);

        // every polynomial at full rate; PRBS15 runs past one full period
        for (int m = 0; m < 4; m++) begin
            do_reset(2'(m));
            for (int i = 0; i < ((m == 1) ? 1100 : 300); i++) rstep(100, 100, 0, 0);
        end

        // random back-pressure and enable gaps
        do_reset(2'd1);
        for (int i = 0; i < 600; i++) rstep(80, 50, 0, 0);

        // error injection while stalled, together with an advance, and alongside load
        do_reset(2'd0);
        for (int i = 0; i < 5; i++) rstep(100, 100, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        for (int i = 0; i < 4; i++) rstep(100, 100, 0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
        for (int i = 0; i < 3; i++) rstep(100, 100, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        for (int i = 0; i < 5; i++) rstep(100, 100, 0, 0);

        // mid-stream reload 00 -> 11, then reset mid-stream
        do_reset(2'd0);
        for (int i = 0; i < 10; i++) rstep(100, 100, 0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'd3);
        for (int i = 0; i < 100; i++) rstep(90, 70, 0, 0);
        do_reset(2'd2);
        for (int i = 0; i < 50; i++) rstep(90, 70, 0, 0);

        // saturating narrow counter: 21 full-rate cycles accept 20 words
        do_reset(2'd0);
        for (int i = 0; i < 21; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'($urandom));
        check("t6_sat4",  64'(bus4.word_cnt), 64'hF);
        check("t6_cnt32", 64'(bus.word_cnt),  64'd20);

        // mixed random traffic including reloads and injections
        do_reset(2'($urandom));
        for (int i = 0; i < 2000; i++) rstep(85, 60, 2, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
